alu_dr_stage_sync: RTL

// - Parametrised dual-rail ALU pipeline stage for the asynchronous datapath, clocked at its core.
// - Four-phase return-to-zero handshake with completion detection on both sides.
// - Adds over the 4-bit generation: WIDTH, a 4-op mode, a DEPTH-entry result FIFO decoupling input/output handshakes, illegal-code detection.
// - Sits between dual-rail operand producers and a dual-rail consumer or the clocked register file.

---
 rtl/alu_dr_stage_sync_pkg.sv | 47 ++++
 rtl/dr_result_fifo.sv | 54 +++++
 rtl/alu_dr_stage_sync.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_dr_stage_sync_pkg.sv
// rtl/alu_dr_stage_sync_pkg.sv - dual-rail pair codes, ALU op codes, FSM states and pair helpers
package alu_dr_stage_sync_pkg;

  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  typedef enum logic {
    IN_DATA,
    IN_RTZ
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_DATA,
    OUT_RTZ
  } out_state_e;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_ONE : DR_ZERO;
  endfunction

  function automatic logic dr_decode(input logic [1:0] p);
    return p == DR_ONE;
  endfunction

  function automatic logic dr_is_valid(input logic [1:0] p);
    return p[1] ^ p[0];
  endfunction

  function automatic logic dr_is_null(input logic [1:0] p);
    return p == DR_NULL;
  endfunction

  function automatic logic dr_is_illegal(input logic [1:0] p);
    return p == DR_ILLEGAL;
  endfunction

endpackage

// File: rtl/dr_result_fifo.sv
// rtl/dr_result_fifo.sv - result FIFO between the input and output handshakes
module dr_result_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop retires the head in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_dr_stage_sync.sv
// rtl/alu_dr_stage_sync.sv - clocked dual-rail ALU stage with four-phase handshakes on both sides
module alu_dr_stage_sync
  import alu_dr_stage_sync_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] a_dr,
  input  logic [2*WIDTH-1:0] b_dr,
  input  logic [3:0]         op_dr,
  output logic               ack_in,
  output logic [2*WIDTH-1:0] res_dr,
  output logic [1:0]         cout_dr,
  output logic [1:0]         neg_dr,
  output logic [1:0]         zero_dr,
  input  logic               ack_out,
  output logic               err
);

  localparam int IW    = 4*WIDTH + 4;
  localparam int NPAIR = IW / 2;
  localparam int FW    = WIDTH + 3;

  logic [IW-1:0] in_s1_q, in_s2_q, in_s3_q;
  logic          ack_s1_q, ack_s2_q;
  logic          cmp_q, cmp_d, null_q, null_d;
  logic          err_q, err_d;
  in_state_e     in_state_q, in_state_d;
  out_state_e    out_state_q, out_state_d;

  logic             all_valid, all_null, any_illegal;
  logic [WIDTH-1:0] a_v, b_v, res_v;
  logic [1:0]       op_v;
  logic [WIDTH:0]   sum_w, diff_w;
  logic             cout_v;
  logic [FW-1:0]    push_word, head;
  logic             push, pop, fifo_full, fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1_q     <= '0;
      in_s2_q     <= '0;
      in_s3_q     <= '0;
      ack_s1_q    <= 1'b0;
      ack_s2_q    <= 1'b0;
      cmp_q       <= 1'b0;
      null_q      <= 1'b0;
      err_q       <= 1'b0;
      in_state_q  <= IN_DATA;
      out_state_q <= OUT_IDLE;
    end else begin
      in_s1_q     <= {op_dr, b_dr, a_dr};
      in_s2_q     <= in_s1_q;
      in_s3_q     <= in_s2_q;
      ack_s1_q    <= ack_out;
      ack_s2_q    <= ack_s1_q;
      cmp_q       <= cmp_d;
      null_q      <= null_d;
      err_q       <= err_d;
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
    end
  end

  always_comb begin
    all_valid   = 1'b1;
    all_null    = 1'b1;
    any_illegal = 1'b0;
    for (int i = 0; i < NPAIR; i++) begin
      all_valid   = all_valid & dr_is_valid(in_s2_q[2*i +: 2]);
      all_null    = all_null & dr_is_null(in_s2_q[2*i +: 2]);
      any_illegal = any_illegal | dr_is_illegal(in_s2_q[2*i +: 2]);
    end
    // A token or spacer only counts once the synced word has held still for a cycle.
    cmp_d  = all_valid && (in_s2_q == in_s3_q);
    null_d = all_null && (in_s2_q == in_s3_q);
    err_d  = err_q | any_illegal;
  end

  always_comb begin
    a_v = '0;
    b_v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_v[i] = dr_decode(in_s2_q[2*i +: 2]);
      b_v[i] = dr_decode(in_s2_q[2*WIDTH + 2*i +: 2]);
    end
    op_v = {dr_decode(in_s2_q[4*WIDTH+2 +: 2]), dr_decode(in_s2_q[4*WIDTH +: 2])};
  end

  always_comb begin
    sum_w  = {1'b0, a_v} + {1'b0, b_v};
    diff_w = {1'b0, a_v} + {1'b0, ~b_v} + {{WIDTH{1'b0}}, 1'b1};
    res_v  = '0;
    cout_v = 1'b0;
    case (alu_op_e'(op_v))
      OP_ADD: {cout_v, res_v} = sum_w;
      OP_SUB: {cout_v, res_v} = diff_w;
      OP_AND: res_v = a_v & b_v;
      OP_OR:  res_v = a_v | b_v;
      default: res_v = '0;
    endcase
    push_word = {cout_v, res_v[WIDTH-1], (res_v == '0), res_v};
  end

  always_comb begin
    in_state_d = in_state_q;
    push       = 1'b0;
    case (in_state_q)
      IN_DATA: begin
        if (cmp_q && cmp_d && (!fifo_full || pop)) begin
          push       = 1'b1;
          in_state_d = IN_RTZ;
        end
      end
      IN_RTZ: begin
        if (null_q && null_d) in_state_d = IN_DATA;
      end
      default: in_state_d = IN_DATA;
    endcase
  end

  always_comb begin
    out_state_d = out_state_q;
    pop         = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (!fifo_empty) out_state_d = OUT_DATA;
      end
      OUT_DATA: begin
        if (ack_s2_q) begin
          pop         = 1'b1;
          out_state_d = OUT_RTZ;
        end
      end
      OUT_RTZ: begin
        if (!ack_s2_q) out_state_d = fifo_empty ? OUT_IDLE : OUT_DATA;
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  // The head entry is only stable while in OUT_DATA, so every other state shows the spacer.
  always_comb begin
    res_dr  = '0;
    cout_dr = DR_NULL;
    neg_dr  = DR_NULL;
    zero_dr = DR_NULL;
    if (out_state_q == OUT_DATA) begin
      for (int i = 0; i < WIDTH; i++) res_dr[2*i +: 2] = dr_encode(head[i]);
      cout_dr = dr_encode(head[WIDTH+2]);
      neg_dr  = dr_encode(head[WIDTH+1]);
      zero_dr = dr_encode(head[WIDTH]);
    end
  end

  assign ack_in = (in_state_q == IN_RTZ);
  assign err    = err_q;

  dr_result_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
